fixed_tile_streamer: RTL and testbench
======================================

Name: fixed_tile_streamer

Overview:
- Transmit-side companion to the attention/matmul datapath. It captures one matrix as a sequence of tiles, then replays the matrix through a valid/ready stream.
- Tiles come out in the block order fixed_matmul consumes. The whole matrix is replayed REPEAT times, because weights must be re-streamed for every input row-block.
- Sits between weight/activation storage and the weight_q/k/v ports of fixed_att.

Parameters:
- DATA_WIDTH, 8, element width in bits.
- ROW_PARALLELISM, 2, rows per tile.
- ROW_NUM_PARALLELISM, 3, number of row-blocks.
- COL_SIZE, 3, columns per tile.
- COL_DEPTH, 3, number of column-blocks.
- REPEAT, 2, full-matrix replays per load; must be >= 1.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- data_in  input  DATA_WIDTH x (ROW_PARALLELISM*COL_SIZE)  tile in; element index r*COL_SIZE+c.
- data_in_valid  input  1  load tile valid.
- data_in_ready  output  1  load tile accepted.
- data_out  output  DATA_WIDTH x (ROW_PARALLELISM*COL_SIZE)  tile out; same element layout.
- data_out_valid  output  1  output tile valid.
- data_out_ready  input  1  downstream accepts.
- stream_done  output  1  one-cycle pulse on final output handshake.

Behaviour:
- Interface: one clock, clk; rst is synchronous, active-high.
- Derived counts: NT = ROW_NUM_PARALLELISM*COL_DEPTH tiles. Tile index t = rb*COL_DEPTH + cb (row-block major, column-block inner).
- Storage: NT-entry tile buffer, registers or LUTRAM. Contents are not reset.
- FSM has two states, LOAD and STREAM. Reset state is LOAD.
- Reset values: data_in_ready=1, data_out_valid=0, stream_done=0, all counters 0.
- LOAD:
  - data_in_ready=1 and data_out_valid=0.
  - Each data_in_valid&&data_in_ready handshake writes buffer[load_cnt] and increments load_cnt.
  - The handshake with load_cnt==NT-1 clears load_cnt and moves to STREAM.
- STREAM:
  - data_in_ready=0; data_in_valid is ignored and no tile is consumed.
  - data_out_valid=1 and data_out = buffer[order(tile_cnt)], driven combinationally from registered state only (no in->out combinational path).
  - On each handshake, tile_cnt increments.
  - At tile_cnt==NT-1, tile_cnt wraps to 0 and rep_cnt increments.
  - The handshake at tile_cnt==NT-1 with rep_cnt==REPEAT-1 does all of the following: asserts stream_done for that same cycle (combinational, qualified by the handshake), clears both counters, and returns to LOAD.
- Latency:
  - First output is valid in the cycle after the last load handshake.
  - Throughput is one tile per cycle in both directions.
  - After the final output handshake, data_in_ready is 1 the next cycle.
- Backpressure: while data_out_valid && !data_out_ready, data_out and all counters hold stable. Valid is never dropped without a handshake.
- Boundary conditions:
  - REPEAT=1: single pass.
  - NT=1: every output handshake wraps.
  - Gaps in data_in_valid during LOAD stall load_cnt.
  - rst at any point (mid-load or mid-stream): next cycle is LOAD with counters 0, data_out_valid=0, stream_done=0. The partially loaded buffer is discarded logically; the next load overwrites it.
- Counter widths: $clog2 of the count, with a minimum of 1 bit.

Optional Feature:
- Macro FIXED_TILE_STREAMER_COL_MAJOR_EN.
- Defined: output order is column-block outer, row-block inner, i.e. order(k) = (k % ROW_NUM_PARALLELISM)*COL_DEPTH + k / ROW_NUM_PARALLELISM. This feeds a transposed consumer (e.g. the inst_fmmc_v-style operand).
- Undefined: order(k) = k.
- Load order is unchanged either way.

Decomposition:
- Package fixed_tile_streamer_pkg holds:
  - state enum {LOAD, STREAM};
  - localparam functions for NT, tile element count and counter widths.
- One natural sub-module: tile_order_gen. It holds tile_cnt and rep_cnt, and produces the read index, the last-tile and last-repeat flags, and done. The macro selects its index mapping.
- The buffer and FSM stay in the top module.

Test Plan (defaults; tile k element e = k*6+e):
- Load tiles 0..8 with data_out_ready=1 constantly:
  - data_in_ready drops the cycle after the 9th load handshake;
  - 18 outputs follow in order 0..8,0..8, back-to-back;
  - stream_done pulses only on beat 18;
  - data_in_ready=1 the next cycle.
- Random data_out_ready (50%) during STREAM: sequence identical to the previous scenario, and data_out stays stable across every stalled cycle.
- Keep data_in_valid=1 with tile value 99 throughout STREAM: 99 is never output. A second load of tiles 100..108 after done streams 100..108 twice.
- Assert rst after the 5th output handshake: next cycle data_out_valid=0 and data_in_ready=1. A fresh load of 0..8 streams correctly from tile 0.
- With FIXED_TILE_STREAMER_COL_MAJOR_EN defined: output order is 0,3,6,1,4,7,2,5,8, repeated twice.
- With REPEAT=1 and load_valid gapped every other cycle: all 9 tiles are captured, 9 outputs follow, and stream_done pulses on beat 9.

Source files
------------

// File: rtl/fixed_tile_streamer_pkg.sv
// Shared types and sizing helpers for fixed_tile_streamer and its tile_order_gen.
package fixed_tile_streamer_pkg;

    typedef enum logic {LOAD, STREAM} state_t;

    function automatic int calc_nt(input int row_num_parallelism, input int col_depth);
        return row_num_parallelism * col_depth;
    endfunction

    function automatic int calc_elems(input int row_parallelism, input int col_size);
        return row_parallelism * col_size;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fixed_tile_streamer_order_gen.sv
// Replay sequencer: walks tile_cnt/rep_cnt and maps them to a buffer read index.
// FIXED_TILE_STREAMER_COL_MAJOR_EN switches the mapping to column-block outer order.
module tile_order_gen
    import fixed_tile_streamer_pkg::*;
#(
    parameter int ROW_NUM_PARALLELISM = 3,
    parameter int COL_DEPTH           = 3,
    parameter int REPEAT              = 2,
    localparam int NT = calc_nt(ROW_NUM_PARALLELISM, COL_DEPTH),
    localparam int TW = cnt_width(NT),
    localparam int RW = cnt_width(REPEAT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          advance,
    output logic [TW-1:0] rd_idx,
    output logic          last_tile,
    output logic          last_rep,
    output logic          done
);

    logic [TW-1:0] tile_cnt;
    logic [RW-1:0] rep_cnt;
    logic [31:0]   k;

    assign last_tile = (tile_cnt == TW'(NT - 1));
    assign last_rep  = (rep_cnt == RW'(REPEAT - 1));
    assign done      = advance && last_tile && last_rep;

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_cnt <= '0;
            rep_cnt  <= '0;
        end else if (advance) begin
            if (last_tile) begin
                tile_cnt <= '0;
                rep_cnt  <= last_rep ? '0 : rep_cnt + 1'b1;
            end else begin
                tile_cnt <= tile_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        k = 32'(tile_cnt);
`ifdef FIXED_TILE_STREAMER_COL_MAJOR_EN
        // Row-block varies fastest so a transposed consumer sees one column-block at a time.
        rd_idx = TW'((k % ROW_NUM_PARALLELISM) * COL_DEPTH + k / ROW_NUM_PARALLELISM);
`else
        rd_idx = TW'(k);
`endif
    end

endmodule

// File: rtl/fixed_tile_streamer.sv
// Captures one matrix as NT tiles, then replays it REPEAT times over a valid/ready stream.
// Optional FIXED_TILE_STREAMER_COL_MAJOR_EN selects column-block-outer replay order.
module fixed_tile_streamer
    import fixed_tile_streamer_pkg::*;
#(
    parameter int DATA_WIDTH          = 8,
    parameter int ROW_PARALLELISM     = 2,
    parameter int ROW_NUM_PARALLELISM = 3,
    parameter int COL_SIZE            = 3,
    parameter int COL_DEPTH           = 3,
    parameter int REPEAT              = 2,
    localparam int NT    = calc_nt(ROW_NUM_PARALLELISM, COL_DEPTH),
    localparam int ELEMS = calc_elems(ROW_PARALLELISM, COL_SIZE),
    localparam int LW    = cnt_width(NT)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [ELEMS-1:0][DATA_WIDTH-1:0] data_in,
    input  logic                             data_in_valid,
    output logic                             data_in_ready,
    output logic [ELEMS-1:0][DATA_WIDTH-1:0] data_out,
    output logic                             data_out_valid,
    input  logic                             data_out_ready,
    output logic                             stream_done
);

    state_t state, state_next;

    logic [LW-1:0]                    load_cnt;
    logic [ELEMS-1:0][DATA_WIDTH-1:0] buffer [NT];
    logic [LW-1:0]                    rd_idx;
    logic                             last_tile, last_rep;
    logic                             in_fire, out_fire, last_load;

    assign data_in_ready  = (state == LOAD);
    assign data_out_valid = (state == STREAM);
    assign in_fire        = data_in_valid && data_in_ready;
    assign out_fire       = data_out_valid && data_out_ready;
    assign last_load      = (load_cnt == LW'(NT - 1));
    assign data_out       = buffer[rd_idx];

    tile_order_gen #(
        .ROW_NUM_PARALLELISM(ROW_NUM_PARALLELISM),
        .COL_DEPTH          (COL_DEPTH),
        .REPEAT             (REPEAT)
    ) u_order (
        .clk      (clk),
        .rst      (rst),
        .advance  (out_fire),
        .rd_idx   (rd_idx),
        .last_tile(last_tile),
        .last_rep (last_rep),
        .done     (stream_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (in_fire && last_load) state_next = STREAM;
            STREAM:  if (out_fire && last_tile && last_rep) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
        end else if (in_fire) begin
            load_cnt <= last_load ? '0 : load_cnt + 1'b1;
        end
    end

    // Buffer is deliberately unreset; a fresh load always overwrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buffer[load_cnt] <= data_in;
        end
    end

endmodule

// File: tb/tb_fixed_tile_streamer.sv
// Directed bench for fixed_tile_streamer: default instance plus a REPEAT=1 instance.
module tb_fixed_tile_streamer;

    localparam int DW = 8;
    localparam int EL = 6;
    localparam int NT = 9;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [EL-1:0][DW-1:0] din, dout0, dout1, cur_dout;
    logic in_valid, out_ready, sel;
    logic in_ready0, in_ready1, out_valid0, out_valid1, done0, done1;
    logic cur_in_ready, cur_out_valid, cur_done;

    int checks = 0;
    int errors = 0;

    fixed_tile_streamer #(
        .DATA_WIDTH(8), .ROW_PARALLELISM(2), .ROW_NUM_PARALLELISM(3),
        .COL_SIZE(3), .COL_DEPTH(3), .REPEAT(2)
    ) dut (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(in_valid && !sel), .data_in_ready(in_ready0),
        .data_out(dout0), .data_out_valid(out_valid0), .data_out_ready(out_ready && !sel),
        .stream_done(done0)
    );

    fixed_tile_streamer #(
        .DATA_WIDTH(8), .ROW_PARALLELISM(2), .ROW_NUM_PARALLELISM(3),
        .COL_SIZE(3), .COL_DEPTH(3), .REPEAT(1)
    ) dut_r1 (
        .clk(clk), .rst(rst),
        .data_in(din), .data_in_valid(in_valid && sel), .data_in_ready(in_ready1),
        .data_out(dout1), .data_out_valid(out_valid1), .data_out_ready(out_ready && sel),
        .stream_done(done1)
    );

    assign cur_dout      = sel ? dout1 : dout0;
    assign cur_in_ready  = sel ? in_ready1 : in_ready0;
    assign cur_out_valid = sel ? out_valid1 : out_valid0;
    assign cur_done      = sel ? done1 : done0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [EL-1:0][DW-1:0] make_tile(input int v);
        logic [EL-1:0][DW-1:0] t;
        for (int e = 0; e < EL; e++) t[e] = 8'(v * 6 + e);
        return t;
    endfunction

    function automatic int order(input int k);
`ifdef FIXED_TILE_STREAMER_COL_MAJOR_EN
        return (k % 3) * 3 + k / 3;
`else
        return k;
`endif
    endfunction

    task automatic loadTiles(input int base, input bit gap);
        for (int i = 0; i < NT; i++) begin
            if (gap) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            @(negedge clk);
            din      = make_tile(base + i);
            in_valid = 1'b1;
            #1;
            checkOutput("load_ready", 64'(cur_in_ready), 64'(1));
        end
    endtask

    task automatic streamCheck(input int base, input int total, input int stop,
                               input bit rand_ready, input bit keep99);
        int beat = 0;
        int cycles = 0;
        bit stalled = 1'b0;
        logic [EL-1:0][DW-1:0] prev = '0;
        while (beat < stop && cycles < 400) begin
            @(negedge clk);
            cycles++;
            in_valid  = keep99;
            din       = make_tile(99);
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            checkOutput("out_valid", 64'(cur_out_valid), 64'(1));
            checkOutput("in_ready_stream", 64'(cur_in_ready), 64'(0));
            if (stalled) checkOutput("stall_stable", 64'(cur_dout), 64'(prev));
            if (out_ready) begin
                checkOutput($sformatf("beat%0d", beat), 64'(cur_dout),
                            64'(make_tile(base + order(beat % NT))));
                checkOutput($sformatf("done_beat%0d", beat), 64'(cur_done), 64'(beat == total - 1));
                beat++;
                stalled = 1'b0;
            end else begin
                checkOutput("done_stalled", 64'(cur_done), 64'(0));
                stalled = 1'b1;
                prev    = cur_dout;
            end
        end
        if (beat < stop) checkOutput("stream_timeout", 64'(beat), 64'(stop));
        if (stop == total) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            checkOutput("post_in_ready", 64'(cur_in_ready), 64'(1));
            checkOutput("post_out_valid", 64'(cur_out_valid), 64'(0));
            checkOutput("post_done", 64'(cur_done), 64'(0));
        end
    endtask

    task automatic applyStimulus();
        sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; din = '0; rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready0), 64'(1));
        checkOutput("rst_out_valid", 64'(out_valid0), 64'(0));
        checkOutput("rst_done", 64'(done0), 64'(0));
        checkOutput("rst_r1_in_ready", 64'(in_ready1), 64'(1));
        rst = 1'b0;

        loadTiles(0, 1'b0);
        streamCheck(0, 18, 18, 1'b0, 1'b0);

        loadTiles(0, 1'b0);
        streamCheck(0, 18, 18, 1'b1, 1'b0);

        loadTiles(0, 1'b0);
        streamCheck(0, 18, 18, 1'b0, 1'b1);
        loadTiles(100, 1'b0);
        streamCheck(100, 18, 18, 1'b0, 1'b0);

        loadTiles(0, 1'b0);
        streamCheck(0, 18, 5, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midrst_out_valid", 64'(out_valid0), 64'(0));
        checkOutput("midrst_in_ready", 64'(in_ready0), 64'(1));
        checkOutput("midrst_done", 64'(done0), 64'(0));
        rst = 1'b0;
        loadTiles(0, 1'b0);
        streamCheck(0, 18, 18, 1'b0, 1'b0);

        sel = 1'b1;
        loadTiles(0, 1'b1);
        streamCheck(0, 9, 9, 1'b0, 1'b0);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
